decoder_2to4_pipe: RTL
======================

Name: decoder_2to4_pipe

Overview:
- Registered 2-to-4 one-hot decoder with a valid/ready handshake on both sides. It is the receive-side counterpart of the 4-to-2 encoder: it turns 2-bit codes back into one-hot lines.
- Keeps a saturating hit counter per output line for debug and coverage.
- Sits downstream of encoder_4to2 in the encode/decode loopback path.

Parameters:
- CNT_W, 8, width of each per-line hit counter (minimum 2).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream code valid.
- in_ready  output  1  decoder can accept a code this cycle.
- a  input  2  code to decode.
- en  input  1  decode enable, sampled with the code. When low, the output word is 4'b0000.
- out_valid  output  1  y holds a decoded word.
- out_ready  input  1  downstream accepts y this cycle.
- y  output  4  one-hot decoded word (bit a set), or zero when disabled.
- clr_cnt  input  1  synchronous clear of all hit counters.
- hit_cnt  output  4*CNT_W  concatenated counters; line k occupies bits [k*CNT_W +: CNT_W].

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high and is sampled only on the rising edge of clk.
- Reset values: out_valid=0, y=4'b0000, hit_cnt=0. in_ready reads 1 after reset.
- Handshake terms:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- in_ready = !out_valid | out_ready. This is combinational from out_ready, so a full single-stage pipe gives full throughput.
- Output register update on the clock edge:
  - in_fire: y <= en ? (4'b0001 << a) : 4'b0000, and out_valid <= 1.
  - else if out_fire: out_valid <= 0 and y holds its last value. The bench does not check y while out_valid=0.
  - else: hold.
- Latency: exactly 1 cycle from in_fire to out_valid=1 with the matching y.
- Back-to-back operation: a new in_fire and an out_fire in the same cycle replace the word with no bubble.
- Stability: while out_valid=1 and out_ready=0, y and out_valid are held stable and in_ready=0 (no overwrite).
- Hit counters:
  - On in_fire with en=1, counter[a] increments.
  - Each counter saturates at 2^CNT_W-1 and does not wrap.
  - Codes taken with en=0 do not count.
- clr_cnt=1 zeroes all counters on that edge.
- clr_cnt has priority over a simultaneous increment: the result is 0, not 1.
- clr_cnt does not affect the datapath or the handshake.
- Reset mid-operation: rst=1 drops any held word (out_valid=0) and clears the counters on that edge.
- Inputs during reset: in_valid is ignored while rst=1, and no counter moves.
- Width rule: a is exactly 2 bits, so every code is legal. y is one-hot or zero, never multi-hot.

Decomposition:
- Shared package codec_pkg:
  - localparams CODE_W=2 and LINES=4.
  - function onehot_of(code).
  - The same package serves the encoder.
- Sub-module sat_counter:
  - Parameters: CNT_W.
  - Ports: clk, rst, clr, inc, cnt.
  - Instantiated 4 times via generate.

Test Plan:
- Reset, then in_valid=1 with a=2, en=1, out_ready=1 -> next cycle out_valid=1, y=4'b0100, hit_cnt line2=1, all other lines 0.
- Stream a=0,1,2,3 on consecutive cycles with out_ready=1 held high -> y=0001,0010,0100,1000 on 4 consecutive cycles, in_ready=1 throughout, each counter=1.
- Hold out_ready=0 after one word (a=3) while upstream offers a=1 -> y stays 1000, in_ready=0. Raise out_ready -> the next cycle shows y=0010.
- en=0 with a=1 accepted -> y=4'b0000 with out_valid=1, and counter line1 is unchanged.
- CNT_W=2: fire a=0 five times -> line0 counter=3 (saturated). Then assert clr_cnt together with a fire of a=0 -> counter=0.
- Assert rst while out_valid=1 and in_valid=1 -> next cycle out_valid=0, all counters 0, in_ready=1.

Source files
------------

// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - shared code/line definitions for the 4-to-2 encoder and 2-to-4 decoder
package codec_pkg;

    localparam int CODE_W = 2;
    localparam int LINES  = 4;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [LINES-1:0]  line_t;

    function automatic line_t onehot_of(input code_t code);
        return line_t'(1) << code;
    endfunction

    // Lowest set line wins; an all-zero word maps to code 0.
    function automatic code_t code_of(input line_t lines);
        code_t code;
        code = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (lines[i]) begin
                code = code_t'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Clear outranks a same-cycle increment so a clear always lands on zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_2to4_pipe.sv
// rtl/decoder_2to4_pipe.sv - registered 2-to-4 one-hot decoder with handshake and per-line hit counters
module decoder_2to4_pipe
    import codec_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CODE_W-1:0]      a,
    input  logic                   en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LINES-1:0]       y,
    input  logic                   clr_cnt,
    output logic [LINES*CNT_W-1:0] hit_cnt
);

    logic             in_fire;
    logic             out_fire;
    logic [LINES-1:0] inc;

    // Single-stage skid-free pipe: a draining word frees the slot in the same cycle.
    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready && !rst;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            y         <= en ? onehot_of(a) : '0;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    for (genvar k = 0; k < LINES; k++) begin : g_line
        assign inc[k] = in_fire && en && (a == code_t'(k));

        sat_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk(clk),
            .rst(rst),
            .clr(clr_cnt),
            .inc(inc[k]),
            .cnt(hit_cnt[k*CNT_W +: CNT_W])
        );
    end

endmodule
